// File: rtl/aes_vec_pkg.sv
// aes_vec_pkg: shared lane width, half-row/state-row types and beat enum for the AES vector datapath
package aes_vec_pkg;
  localparam int LANE_W_DEF = 8;
  typedef logic [2*LANE_W_DEF-1:0] half_row_t;
  typedef logic [4*LANE_W_DEF-1:0] state_row_t;
  typedef enum logic {BEAT0, BEAT1} beat_e;
endpackage

// File: rtl/state_row_assembler_if.sv
// state_row_assembler_if: half-row input beats and assembled-row output handshake
//   in_valid/in_ready/in_first, half_row0..3 : upstream beat from the packing stage
//   out_valid/out_ready, row0..3             : complete 4-row state to the consumer
interface state_row_assembler_if import aes_vec_pkg::*; #(parameter int LANE_W = LANE_W_DEF);
  logic in_valid, in_ready, in_first;
  logic [2*LANE_W-1:0] half_row0, half_row1, half_row2, half_row3;
  logic out_valid, out_ready;
  logic [4*LANE_W-1:0] row0, row1, row2, row3;
  modport slave (
    input in_valid, in_first, half_row0, half_row1, half_row2, half_row3, out_ready,
    output in_ready, out_valid, row0, row1, row2, row3
  );
  modport master (
    output in_valid, in_first, half_row0, half_row1, half_row2, half_row3, out_ready,
    input in_ready, out_valid, row0, row1, row2, row3
  );
endinterface

// File: rtl/out_skid_reg.sv
// out_skid_reg: single-entry valid/ready output register
//   i_load : capture i_data and assert o_valid
//   i_ready: consumer accepts; o_valid drops unless reloaded in the same cycle
//   o_valid/o_data : held entry
module out_skid_reg import aes_vec_pkg::*; #(parameter int W = 4*$bits(state_row_t)) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (i_load) o_data <= i_data;
      o_valid <= i_load || (o_valid && !i_ready);
    end
  end
endmodule

// File: rtl/state_row_assembler.sv
// state_row_assembler: joins two half-row beats into four 32-bit AES state rows
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop a partial block; the output register still drains
//   proto_err  : sticky in_first mismatch flag
//   bus        : input beats and output rows (state_row_assembler_if.slave)
module state_row_assembler import aes_vec_pkg::*; #(parameter int LANE_W = LANE_W_DEF) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic proto_err,
  state_row_assembler_if.slave bus
);
  localparam int HALF_W = 2*LANE_W;
  localparam int ROW_W  = 4*LANE_W;
  beat_e r_beat;
  logic [4*HALF_W-1:0] r_stage, w_half;
  logic [4*ROW_W-1:0] w_rows_d, w_rows_q;
  logic w_acc, w_restage, w_load;
  assign w_half = {bus.half_row0, bus.half_row1, bus.half_row2, bus.half_row3};
  assign bus.in_ready = !flush && (r_beat == BEAT0 || !bus.out_valid || bus.out_ready);
  assign w_acc = bus.in_valid && bus.in_ready;
  // an in_first on beat 1 abandons the staged half and restarts the block
  assign w_restage = r_beat == BEAT0 || bus.in_first;
  assign w_load = w_acc && !w_restage;
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign w_rows_d[i*ROW_W +: ROW_W] = {r_stage[i*HALF_W +: HALF_W], w_half[i*HALF_W +: HALF_W]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat    <= BEAT0;
      r_stage   <= '0;
      proto_err <= 1'b0;
    end else if (flush) begin
      r_beat <= BEAT0;
    end else if (w_acc) begin
      r_beat <= w_restage ? BEAT1 : BEAT0;
      if (w_restage) r_stage <= w_half;
      // error when beat 0 lacks in_first or beat 1 carries it
      proto_err <= proto_err | ((r_beat == BEAT0) ^ bus.in_first);
    end
  end
  out_skid_reg #(.W(4*ROW_W)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_rows_d),
    .i_ready (bus.out_ready),
    .o_valid (bus.out_valid),
    .o_data  (w_rows_q)
  );
  assign bus.row0 = w_rows_q[4*ROW_W-1 -: ROW_W];
  assign bus.row1 = w_rows_q[3*ROW_W-1 -: ROW_W];
  assign bus.row2 = w_rows_q[2*ROW_W-1 -: ROW_W];
  assign bus.row3 = w_rows_q[ROW_W-1 -: ROW_W];
endmodule

// File: tb/tb_state_row_assembler.sv
// tb_state_row_assembler: directed vector table plus streaming blocks for state_row_assembler
module tb_state_row_assembler;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  typedef struct {
    logic rst_n, in_valid, in_first, flush, out_ready;
    logic [63:0] h;
    logic exp_ir, exp_ov;
    logic [127:0] exp_rows;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, flush, proto_err;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[24];
  state_row_assembler_if bus();
  state_row_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .proto_err (proto_err),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rs, iv, fi, fl, ordy, input logic [63:0] h,
                              input logic ir, ov, input logic [127:0] rows, input logic er);
    vec_t t;
    t.rst_n = rs; t.in_valid = iv; t.in_first = fi; t.flush = fl; t.out_ready = ordy;
    t.h = h; t.exp_ir = ir; t.exp_ov = ov; t.exp_rows = rows; t.exp_err = er;
    return t;
  endfunction
  function automatic logic [127:0] rows_of(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[127-32*k -: 32] = {a[63-16*k -: 16], b[63-16*k -: 16]};
    return r;
  endfunction
  task automatic step(input string name, input vec_t t);
    logic [127:0] rows;
    rst_n = t.rst_n; flush = t.flush;
    bus.in_valid = t.in_valid; bus.in_first = t.in_first; bus.out_ready = t.out_ready;
    {bus.half_row0, bus.half_row1, bus.half_row2, bus.half_row3} = t.h;
    #1;
    n_vec++;
    if (bus.in_ready !== t.exp_ir) begin
      n_err++;
      $display("FAIL %s in_ready got %b want %b", name, bus.in_ready, t.exp_ir);
    end
    @(posedge clk);
    #1;
    rows = {bus.row0, bus.row1, bus.row2, bus.row3};
    if (bus.out_valid !== t.exp_ov) begin
      n_err++;
      $display("FAIL %s out_valid got %b want %b", name, bus.out_valid, t.exp_ov);
    end
    if (rows !== t.exp_rows) begin
      n_err++;
      $display("FAIL %s rows got %h want %h", name, rows, t.exp_rows);
    end
    if (proto_err !== t.exp_err) begin
      n_err++;
      $display("FAIL %s proto_err got %b want %b", name, proto_err, t.exp_err);
    end
    @(negedge clk);
  endtask
  initial begin
    logic [63:0] a0, a1, b0, b1, c0, d0, d1, e0, f0, f1, g0, g1, a, b;
    logic [127:0] ra, rb, rd, rf, rg, prev;
    a0 = 64'h0011_2233_4455_6677; a1 = 64'h8899_AABB_CCDD_EEFF;
    b0 = 64'h1111_2222_3333_4444; b1 = 64'h5555_6666_7777_8888;
    c0 = 64'hDEAD_BEEF_CAFE_F00D;
    d0 = 64'h0102_0304_0506_0708; d1 = 64'h090A_0B0C_0D0E_0F10;
    e0 = 64'hA1A2_A3A4_A5A6_A7A8;
    f0 = 64'hB1B2_B3B4_B5B6_B7B8; f1 = 64'hC1C2_C3C4_C5C6_C7C8;
    g0 = 64'h1234_5678_9ABC_DEF0; g1 = 64'h0FED_CBA9_8765_4321;
    ra = 128'h00118899_2233AABB_4455CCDD_6677EEFF;
    rb = 128'h11115555_22226666_33337777_44448888;
    rd = 128'h0102090A_03040B0C_05060D0E_07080F10;
    rf = 128'hB1B2C1C2_B3B4C3C4_B5B6C5C6_B7B8C7C8;
    rg = 128'h12340FED_5678CBA9_9ABC8765_DEF04321;
    tbl[0]  = mk(H, L, L, L, H, 64'h0,        H, L, 128'h0, L);
    tbl[1]  = mk(H, H, H, L, H, a0,           H, L, 128'h0, L);
    tbl[2]  = mk(H, H, L, L, H, a1,           H, H, ra,     L);
    tbl[3]  = mk(H, L, L, L, H, 64'h0,        H, L, ra,     L);
    tbl[4]  = mk(H, H, H, L, L, a0,           H, L, ra,     L);
    tbl[5]  = mk(H, H, L, L, L, a1,           H, H, ra,     L);
    tbl[6]  = mk(H, H, H, L, L, b0,           H, H, ra,     L);
    tbl[7]  = mk(H, H, L, L, L, b1,           L, H, ra,     L);
    tbl[8]  = mk(H, H, L, L, H, b1,           H, H, rb,     L);
    tbl[9]  = mk(H, L, L, L, H, 64'h0,        H, L, rb,     L);
    tbl[10] = mk(H, H, H, L, H, c0,           H, L, rb,     L);
    tbl[11] = mk(H, H, L, H, H, 64'hFFFF_FFFF_FFFF_FFFF, L, L, rb, L);
    tbl[12] = mk(H, H, H, L, H, d0,           H, L, rb,     L);
    tbl[13] = mk(H, H, L, L, H, d1,           H, H, rd,     L);
    tbl[14] = mk(H, L, L, L, H, 64'h0,        H, L, rd,     L);
    tbl[15] = mk(H, H, H, L, H, e0,           H, L, rd,     L);
    tbl[16] = mk(H, H, H, L, H, f0,           H, L, rd,     H);
    tbl[17] = mk(H, H, L, L, H, f1,           H, H, rf,     H);
    tbl[18] = mk(H, L, L, L, H, 64'h0,        H, L, rf,     H);
    tbl[19] = mk(H, H, H, L, L, g0,           H, L, rf,     H);
    tbl[20] = mk(H, H, L, L, L, g1,           H, H, rg,     H);
    tbl[21] = mk(H, H, H, L, L, b0,           H, H, rg,     H);
    tbl[22] = mk(L, L, L, L, L, 64'h0,        L, L, 128'h0, L);
    tbl[23] = mk(H, L, L, L, H, 64'h0,        H, L, 128'h0, L);
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.out_ready = 1'b0;
    {bus.half_row0, bus.half_row1, bus.half_row2, bus.half_row3} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 24; i++) step($sformatf("vec%0d", i), tbl[i]);
    prev = 128'h0;
    for (int k = 0; k < 8; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      step($sformatf("stream%0d_b0", k), mk(H, H, H, L, H, a, H, L, prev, L));
      prev = rows_of(a, b);
      step($sformatf("stream%0d_b1", k), mk(H, H, L, L, H, b, H, H, prev, L));
    end
    step("stream_idle", mk(H, L, L, L, H, 64'h0, H, L, prev, L));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
